// File: rtl/l2_mem_arbiter.sv
// Two-requester round-robin arbiter sharing one L2 port between the I-side
// and D-side L1 miss interfaces. One transaction at a time; downstream
// request fields are latched on the grant edge and held until l2_resp.
module l2_mem_arbiter #(
  parameter int unsigned LINE_W = 128,
  parameter int unsigned ADDR_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_read,
  input  logic              i_write,
  input  logic [ADDR_W-1:0] i_address,
  input  logic [LINE_W-1:0] i_wdata,
  output logic [LINE_W-1:0] i_rdata,
  output logic              i_resp,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_address,
  input  logic [LINE_W-1:0] d_wdata,
  output logic [LINE_W-1:0] d_rdata,
  output logic              d_resp,
  output logic              l2_read,
  output logic              l2_write,
  output logic [ADDR_W-1:0] l2_address,
  output logic [LINE_W-1:0] l2_wdata,
  input  logic [LINE_W-1:0] l2_rdata,
  input  logic              l2_resp,
  output logic [1:0]        grant
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2
  } state_t;

  state_t            state;
  state_t            state_nx;
  logic              last_owner;
  logic              last_owner_nx;
  logic              l2_read_nx;
  logic              l2_write_nx;
  logic [ADDR_W-1:0] l2_address_nx;
  logic [LINE_W-1:0] l2_wdata_nx;
  logic [1:0]        grant_nx;
  logic              i_pend;
  logic              d_pend;
  logic              pick_i;
  logic              pick_d;

  // State and latched downstream request registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      last_owner <= 1'b1;
      l2_read    <= 1'b0;
      l2_write   <= 1'b0;
      l2_address <= '0;
      l2_wdata   <= '0;
      grant      <= 2'b00;
    end else begin
      state      <= state_nx;
      last_owner <= last_owner_nx;
      l2_read    <= l2_read_nx;
      l2_write   <= l2_write_nx;
      l2_address <= l2_address_nx;
      l2_wdata   <= l2_wdata_nx;
      grant      <= grant_nx;
    end
  end

  // Arbitration, latch selection and response routing.
  always_comb begin
    state_nx      = state;
    last_owner_nx = last_owner;
    l2_read_nx    = l2_read;
    l2_write_nx   = l2_write;
    l2_address_nx = l2_address;
    l2_wdata_nx   = l2_wdata;
    grant_nx      = grant;
    i_resp        = 1'b0;
    d_resp        = 1'b0;
    i_rdata       = '0;
    d_rdata       = '0;

    i_pend = i_read | i_write;
    d_pend = d_read | d_write;
    // On a tie the side that did not go last wins.
    pick_i = i_pend & (~d_pend | last_owner);
    pick_d = d_pend & ~pick_i;

    case (state)
      IDLE: begin
        if (pick_i) begin
          state_nx      = SERVE_I;
          grant_nx      = 2'b01;
          l2_write_nx   = i_write;
          l2_read_nx    = i_read & ~i_write;
          l2_address_nx = i_address;
          l2_wdata_nx   = i_wdata;
        end else if (pick_d) begin
          state_nx      = SERVE_D;
          grant_nx      = 2'b10;
          l2_write_nx   = d_write;
          l2_read_nx    = d_read & ~d_write;
          l2_address_nx = d_address;
          l2_wdata_nx   = d_wdata;
        end
      end
      SERVE_I: begin
        if (l2_resp) begin
          i_resp        = 1'b1;
          i_rdata       = l2_rdata;
          state_nx      = IDLE;
          last_owner_nx = 1'b0;
          l2_read_nx    = 1'b0;
          l2_write_nx   = 1'b0;
          grant_nx      = 2'b00;
        end
      end
      SERVE_D: begin
        if (l2_resp) begin
          d_resp        = 1'b1;
          d_rdata       = l2_rdata;
          state_nx      = IDLE;
          last_owner_nx = 1'b1;
          l2_read_nx    = 1'b0;
          l2_write_nx   = 1'b0;
          grant_nx      = 2'b00;
        end
      end
      default: begin
        state_nx    = IDLE;
        l2_read_nx  = 1'b0;
        l2_write_nx = 1'b0;
        grant_nx    = 2'b00;
      end
    endcase
  end

endmodule
